// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree, one register layer per tree level, followed by a
// saturating group accumulator. Valid/ready handshake with a single global advance.
module pipelined_adder_tree #(
  parameter  int INPUT_BW   = 8,
  parameter  int LAYER_NUM  = 3,
  parameter  int ARRAY_SIZE = 8,
  parameter  int ACC_EXT    = 4,
  localparam int OUTPUT_BW  = INPUT_BW + LAYER_NUM + ACC_EXT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [INPUT_BW-1:0]  operands [ARRAY_SIZE-1:0],
  input  logic                        acc_en,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUTPUT_BW-1:0] result,
  output logic                        ovf
);

  localparam int TREE_BW = INPUT_BW + LAYER_NUM;

  if (ARRAY_SIZE != (1 << LAYER_NUM)) begin : g_bad_size
    $error("pipelined_adder_tree: ARRAY_SIZE must equal 2**LAYER_NUM");
  end

  logic adv;
  logic out_valid_q, out_valid_d;

  // The whole pipeline, bubbles included, moves only when the output slot frees up.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  logic [LAYER_NUM-1:0] stg_vld_q, stg_acc_q, stg_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q  <= '0;
      stg_acc_q  <= '0;
      stg_last_q <= '0;
    end else if (adv) begin
      stg_vld_q  <= LAYER_NUM'({stg_vld_q, in_valid});
      stg_acc_q  <= LAYER_NUM'({stg_acc_q, acc_en});
      stg_last_q <= LAYER_NUM'({stg_last_q, in_last});
    end
  end

  for (genvar l = 0; l < LAYER_NUM; l++) begin : g_layer
    localparam int W = INPUT_BW + l + 1;
    localparam int N = ARRAY_SIZE >> (l + 1);
    logic signed [W-1:0] sum_q [N];

    if (l == 0) begin : g_leaf
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) sum_q[i] <= '0;
        end else if (adv) begin
          for (int i = 0; i < N; i++)
            sum_q[i] <= {operands[2*i][INPUT_BW-1], operands[2*i]}
                      + {operands[2*i+1][INPUT_BW-1], operands[2*i+1]};
        end
      end
    end else begin : g_node
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) sum_q[i] <= '0;
        end else if (adv) begin
          for (int i = 0; i < N; i++)
            sum_q[i] <= {g_layer[l-1].sum_q[2*i][W-2], g_layer[l-1].sum_q[2*i]}
                      + {g_layer[l-1].sum_q[2*i+1][W-2], g_layer[l-1].sum_q[2*i+1]};
        end
      end
    end
  end

  logic signed [TREE_BW-1:0]   tree_s;
  logic signed [OUTPUT_BW-1:0] s_ext;
  logic        [OUTPUT_BW:0]   sum_wide;
  logic signed [OUTPUT_BW-1:0] sat_sum;
  logic                        clamp;

  logic signed [OUTPUT_BW-1:0] accum_q, accum_d;
  logic                        gov_q, gov_d;
  logic                        first_q, first_d;
  logic                        tree_vld, tree_acc, tree_last;

  localparam logic [OUTPUT_BW-1:0] SAT_MAX = {1'b0, {(OUTPUT_BW-1){1'b1}}};
  localparam logic [OUTPUT_BW-1:0] SAT_MIN = {1'b1, {(OUTPUT_BW-1){1'b0}}};

  assign tree_s    = g_layer[LAYER_NUM-1].sum_q[0];
  assign s_ext     = OUTPUT_BW'(tree_s);
  assign tree_vld  = stg_vld_q[LAYER_NUM-1];
  assign tree_acc  = stg_acc_q[LAYER_NUM-1];
  assign tree_last = stg_last_q[LAYER_NUM-1];

  // One guard bit: sign disagreement between the top two bits means the sum left range.
  assign sum_wide = {accum_q[OUTPUT_BW-1], accum_q} + {s_ext[OUTPUT_BW-1], s_ext};
  assign clamp    = sum_wide[OUTPUT_BW] != sum_wide[OUTPUT_BW-1];
  assign sat_sum  = !clamp ? sum_wide[OUTPUT_BW-1:0]
                  : (sum_wide[OUTPUT_BW] ? SAT_MIN : SAT_MAX);

  always_comb begin
    accum_d     = accum_q;
    gov_d       = gov_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (tree_vld) begin
        if (first_q || !tree_acc) begin
          accum_d = s_ext;
          gov_d   = 1'b0;
        end else begin
          accum_d = sat_sum;
          gov_d   = gov_q | clamp;
        end
        out_valid_d = !tree_acc || tree_last;
        first_d     = !tree_acc || tree_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q     <= '0;
      gov_q       <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      accum_q     <= accum_d;
      gov_q       <= gov_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = accum_q;
  assign ovf       = gov_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: expected results are queued at issue
// time and a negedge monitor pops and compares them on every output transfer.
module tb_pipelined_adder_tree;

  localparam int IBW = 8;
  localparam int LN  = 3;
  localparam int AS  = 8;
  localparam int OBW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic acc_en = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [IBW-1:0] operands [AS-1:0];
  logic in_ready, out_valid, ovf;
  logic signed [OBW-1:0] result;

  always #5 clk = ~clk;

  pipelined_adder_tree #(
    .INPUT_BW(IBW), .LAYER_NUM(LN), .ARRAY_SIZE(AS), .ACC_EXT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operands(operands), .acc_en(acc_en), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .ovf(ovf)
  );

  typedef struct {
    logic signed [OBW-1:0] res;
    logic                  ovf;
  } exp_t;

  exp_t sb[$];
  int   out_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0d expected=none", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("ovf", ovf, mon_e.ovf);
      end
      out_cyc.push_back(cyc);
    end
  end

  function automatic logic [63:0] mk(input int v0, input int vr);
    logic [63:0] v;
    for (int i = 0; i < AS; i++) v[8*i +: 8] = (i == 0) ? 8'(v0) : 8'(vr);
    return v;
  endfunction

  // Called in the posedge+1 phase; returns in that phase after the accepting edge.
  task automatic send(input logic [63:0] v, input bit ae, input bit last,
                      input bit push, input int exp_res, input bit exp_ovf);
    bit acc;
    int n;
    for (int i = 0; i < AS; i++) operands[i] = v[8*i +: 8];
    in_valid = 1'b1;
    acc_en   = ae;
    in_last  = last;
    if (push) sb.push_back('{OBW'(exp_res), exp_ovf});
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    @(posedge clk);
    #1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int t0;
  int wn;

  initial begin
    for (int i = 0; i < AS; i++) operands[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single beats, latency
    t0 = cyc;
    send(mk(127, 127), 0, 0, 1, 1016, 0);
    wn = 0;
    do begin
      @(negedge clk);
      wn++;
    end while (!out_valid && wn < 20);
    check("latency", cyc - t0, 4);
    drain();
    send(mk(-128, -128), 0, 0, 1, -1024, 0);
    drain();

    // 2: in_last ignored without acc_en; back-to-back throughput
    send(64'h0807060504030201, 0, 0, 1, 36, 0);
    drain();
    out_cyc.delete();
    send(mk(-5, 3),     0, 0, 1, 16,   0);
    send(mk(100, -100), 0, 1, 1, -600, 0);
    send(mk(7, -1),     0, 0, 1, 0,    0);
    send(mk(-128, 127), 0, 0, 1, 761,  0);
    drain();
    check("b2b_count", out_cyc.size(), 4);
    if (out_cyc.size() == 4) check("b2b_spacing", out_cyc[3] - out_cyc[0], 3);

    // 3: accumulation and saturation
    for (int i = 0; i < 16; i++) send(mk(127, 127), 1, i == 15, i == 15, 16256, 0);
    drain();
    for (int i = 0; i < 17; i++) send(mk(127, 127), 1, i == 16, i == 16, 16383, 1);
    drain();
    for (int i = 0; i < 17; i++) send(mk(-128, -128), 1, i == 16, i == 16, -16384, 1);
    drain();

    // 4: output stall
    fork
      begin
        for (int k = 1; k <= 6; k++) send(mk(k, k), 0, 0, 1, 8 * k, 0);
      end
      begin
        int sn;
        sn = 0;
        do begin
          @(negedge clk);
          sn++;
        end while (!out_valid && sn < 50);
        check("stall_wait", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_result", result, 16);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // 5: asynchronous reset in the middle of a group
    for (int i = 0; i < 3; i++) send(mk(1, 2), 1, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_result", result, 0);
    check("async_in_ready", in_ready, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(mk(1, 1), 1, 1, 1, 8, 0);
    drain();

    // 6: group followed by a plain beat, then a plain beat interrupting a group
    send(mk(10, 0), 1, 0, 0, 0, 0);
    send(mk(20, 0), 1, 0, 0, 0, 0);
    send(mk(30, 0), 1, 1, 1, 60, 0);
    send(mk(5, 0),  0, 0, 1, 5, 0);
    drain();
    send(mk(10, 0), 1, 0, 0, 0, 0);
    send(mk(20, 0), 1, 0, 0, 0, 0);
    send(mk(5, 0),  0, 0, 1, 5, 0);
    send(mk(10, 0), 1, 0, 0, 0, 0);
    send(mk(20, 0), 1, 0, 0, 0, 0);
    send(mk(30, 0), 1, 1, 1, 60, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Parametrised, fully pipelined signed adder tree with one register per tree layer.
- Valid/ready flow control on input and output.
- Optional multi-beat accumulation with saturation and an overflow flag.
- Next-generation reduction block for dot-product/MAC datapaths. Takes one vector of ARRAY_SIZE signed operands per accepted beat and emits either the per-beat sum or a sum accumulated over a group of beats.

Parameters:
- INPUT_BW, 8, bit width of each signed operand.
- LAYER_NUM, 3, number of adder layers; ARRAY_SIZE must equal 2**LAYER_NUM (elaboration error otherwise).
- ARRAY_SIZE, 8, operands per beat.
- ACC_EXT, 4, extra accumulator guard bits beyond the full tree width.
- OUTPUT_BW, INPUT_BW+LAYER_NUM+ACC_EXT (15), result width; fixed by formula, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept a beat this cycle.
- operands  in  ARRAY_SIZE x INPUT_BW signed (unpacked array [ARRAY_SIZE-1:0])  operand vector.
- acc_en  in  1  beat belongs to an accumulation group.
- in_last  in  1  final beat of group; ignored when acc_en=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  OUTPUT_BW signed  sum / accumulated sum.
- ovf  out  1  saturation occurred in the group; qualified by out_valid.

Behaviour:
- Reset (async assert, sync release): all stage valid bits, out_valid, ovf cleared; result=0; accumulator "first" flag=1; in_ready=1. Reset mid-operation discards in-flight beats and any partial group.
- Global advance: adv = !out_valid || out_ready; in_ready = adv. A beat is accepted when in_valid && in_ready. Whole pipeline (bubbles included) shifts only when adv=1; otherwise every stage holds.
- Layer L (0..LAYER_NUM-1) register width INPUT_BW+L+1. Each pair is sign-extended one bit and added, so tree math never overflows. Each stage carries a valid bit plus its acc_en/in_last tags.
- Final stage is the accumulator, total latency LAYER_NUM+1 cycles from acceptance to out_valid with no stall (4 at defaults).
- Accumulator update, on adv with a valid tree output s, sign-extended to OUTPUT_BW:
  - If first=1 or acc_en=0: acc = s, group ovf = 0.
  - Otherwise: acc = sat(acc + s), clamped to [-2**(OUTPUT_BW-1), 2**(OUTPUT_BW-1)-1]. Group ovf |= clamp occurred.
- Emit = (acc_en==0) || in_last. On emit: out_valid=1, result=acc, ovf = group ovf, first=1. On non-emit: out_valid=0, first=0.
- result/ovf hold stable while out_valid && !out_ready.
- Clamping is sticky for the group: once clamped, later beats continue from the clamped value.
- acc_en=0 beat arriving mid-group: closes nothing. It starts a fresh single-beat output, and the open partial group is discarded.
- No combinational path from in_valid/operands to outputs. in_ready depends combinationally only on out_valid and out_ready.

Test Plan:
1. Defaults, one beat all operands 127, acc_en=0 -> out_valid exactly 4 cycles later, result=1016, ovf=0. Repeat with all -128 -> result=-1024.
2. Operands 1..8, acc_en=0, in_last=0 -> result=36 emitted anyway. Back-to-back beats every cycle -> one result per cycle, in order.
3. Accumulate 16 beats all 127, in_last on the 16th -> single out_valid, result=16256, ovf=0. 17 beats -> result=16383, ovf=1. Same with -128 x17 -> result=-16384, ovf=1.
4. Stream 6 beats; hold out_ready=0 for 5 cycles once out_valid rises -> in_ready=0 during stall, result stable. On release, all 6 results appear in order, none lost or duplicated.
5. Assert rst_n low after 3 beats of an accumulation group -> out_valid=0, result=0 immediately (async). After release, one beat all 1s, acc_en=1, in_last=1 -> result=8, ovf=0.
6. Group of 3 accumulate beats (sums 10, 20, 30) with a following acc_en=0 beat (sum 5) in consecutive cycles -> outputs 60 then 5. Interleaving the acc_en=0 beat before the last beat -> partial discarded, next group restarts from its own first beat.
